// File: rtl/debounce_ctrl.sv
// debounce_ctrl: 2-flop synchroniser plus tick-timed debounce FSM issuing press/release/long pulses.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat pulses while a long press is held.
module debounce_ctrl #(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_in,
    output logic             debounced,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic             repeat_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int HW = $clog2(LONG_TICKS + 1);

    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    state_t          r_state;
    logic            r_s1;
    logic            r_s2;
    logic [PW-1:0]   r_pre;
    logic [SW-1:0]   r_stab;
    logic [HW-1:0]   r_hold;
    logic            r_long_flag;

    logic            w_sync;
    logic            w_tick;

    assign w_sync = r_s2;
    assign w_tick = (r_pre == PRE_MAX);

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
    logic [RW-1:0] r_rep;
`else
    assign repeat_pulse = 1'b0 & (REPEAT_TICKS > 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_pre         <= '0;
            r_stab        <= '0;
            r_hold        <= '0;
            r_long_flag   <= 1'b0;
            debounced     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
`ifdef DEBOUNCE_REPEAT_EN
            r_rep         <= '0;
            repeat_pulse  <= 1'b0;
`endif
        end else begin
            r_s1          <= button_in;
            r_s2          <= r_s1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            // Every state change restarts the prescaler so timing counts from entry
            unique case (r_state)
                IDLE: begin
                    if (w_sync) begin
                        r_state <= WAIT_PRESS;
                        r_pre   <= '0;
                        r_stab  <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!w_sync) begin
                        r_state <= IDLE;
                        r_pre   <= '0;
                    end else if (w_tick) begin
                        if (r_stab == STAB_MAX) begin
                            r_state     <= PRESSED;
                            r_pre       <= '0;
                            press_pulse <= 1'b1;
                            debounced   <= 1'b1;
                            press_count <= press_count + 1'b1;
                            r_hold      <= '0;
                            r_long_flag <= 1'b0;
                        end else begin
                            r_stab <= r_stab + 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!w_sync) begin
                        r_state <= WAIT_RELEASE;
                        r_pre   <= '0;
                        r_stab  <= '0;
                    end else if (w_tick) begin
                        if (!r_long_flag && r_hold == HOLD_LAST) begin
                            long_pulse  <= 1'b1;
                            r_long_flag <= 1'b1;
                            r_hold      <= '0;
`ifdef DEBOUNCE_REPEAT_EN
                            r_rep       <= '0;
`endif
                        end else begin
                            if (r_hold != HOLD_MAX) r_hold <= r_hold + 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                            if (r_long_flag) begin
                                if (r_rep == REP_LAST) begin
                                    repeat_pulse <= 1'b1;
                                    r_rep        <= '0;
                                end else begin
                                    r_rep <= r_rep + 1'b1;
                                end
                            end
`endif
                        end
                    end
                end
                WAIT_RELEASE: begin
                    if (w_sync) begin
                        r_state <= PRESSED;
                        r_pre   <= '0;
`ifdef DEBOUNCE_REPEAT_EN
                        r_rep   <= '0;
`endif
                    end else if (w_tick) begin
                        if (r_stab == STAB_MAX) begin
                            r_state       <= IDLE;
                            r_pre         <= '0;
                            release_pulse <= 1'b1;
                            debounced     <= 1'b0;
                        end else begin
                            r_stab <= r_stab + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_ctrl.sv
// Scoreboard bench for debounce_ctrl: a run-length/tick-count reference model
// predicts pulses; a negedge monitor pops and compares them.
module tb_debounce_ctrl;

    localparam int TD   = 4;
    localparam int DT   = 3;
    localparam int LT   = 5;
    localparam int RT   = 2;
    localparam int CW   = 8;
    localparam int QUAL = DT * TD;

`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    localparam logic [3:0] K_PRESS = 4'b1000;
    localparam logic [3:0] K_REL   = 4'b0100;
    localparam logic [3:0] K_LONG  = 4'b0010;
    localparam logic [3:0] K_REP   = 4'b0001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          button_in = 1'b0;
    logic          debounced;
    logic          press_pulse;
    logic          release_pulse;
    logic          long_pulse;
    logic          repeat_pulse;
    logic [CW-1:0] press_count;

    typedef struct {
        int            cyc;
        logic [3:0]    kind;
        logic [CW-1:0] cnt;
    } ev_t;

    ev_t q[$];
    int  compared = 0;
    int  mismatched = 0;
    int  cyc = 0;

    // reference model state
    bit            m1 = 0, m2 = 0, lvl = 0, long_done = 0;
    int            run_start = -1, seg_start = -1, ticks = 0, rep = 0;
    logic [CW-1:0] cnt = '0;

    debounce_ctrl #(
        .TICK_DIV      (TD),
        .DEBOUNCE_TICKS(DT),
        .LONG_TICKS    (LT),
        .REPEAT_TICKS  (RT),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_in    (button_in),
        .debounced    (debounced),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(logic [3:0] k);
        ev_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.cnt  = cnt;
        q.push_back(e);
    endtask

    // A level change qualifies once the synchronised input has differed from the
    // qualified level for QUAL+1 consecutive edges; hold ticks count every TD edges
    // from the start of each uninterrupted pressed segment.
    task automatic model_step(bit y);
        if (!lvl) begin
            if (y) begin
                if (run_start < 0) run_start = cyc;
                else if (cyc - run_start == QUAL) begin
                    lvl = 1; run_start = -1; seg_start = cyc;
                    ticks = 0; long_done = 0; rep = 0;
                    cnt = cnt + 1'b1;
                    push(K_PRESS);
                end
            end else begin
                run_start = -1;
            end
        end else begin
            if (!y) begin
                if (run_start < 0) begin
                    run_start = cyc;
                    seg_start = -1;
                end else if (cyc - run_start == QUAL) begin
                    lvl = 0; run_start = -1;
                    push(K_REL);
                end
            end else if (run_start >= 0) begin
                run_start = -1; seg_start = cyc; rep = 0;
            end else if (cyc > seg_start && (cyc - seg_start) % TD == 0) begin
                ticks++;
                if (!long_done && ticks == LT) begin
                    long_done = 1; rep = 0;
                    push(K_LONG);
                end else if (long_done && REP_EN) begin
                    rep++;
                    if (rep == RT) begin
                        rep = 0;
                        push(K_REP);
                    end
                end
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m1 = 0; m2 = 0; lvl = 0; long_done = 0;
            run_start = -1; seg_start = -1; ticks = 0; rep = 0;
            cnt = '0;
            q.delete();
        end else begin
            bit y;
            y = m2;
            m2 = m1;
            m1 = button_in;
            cyc++;
            model_step(y);
        end
    end

    always @(negedge clk) begin
        logic [3:0] p;
        p = {press_pulse, release_pulse, long_pulse, repeat_pulse};
        if (reset) begin
            chk("reset_pulses", int'(p), 0);
            chk("reset_debounced", int'(debounced), 0);
            chk("reset_count", int'(press_count), 0);
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missed_pulse", 0, int'(q[0].kind));
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                chk("pulse_kind", int'(p), int'(q[0].kind));
                if (q[0].kind == K_PRESS)
                    chk("press_count_at_press", int'(press_count), int'(q[0].cnt));
                void'(q.pop_front());
            end else begin
                chk("no_pulse", int'(p), 0);
            end
            chk("debounced", int'(debounced), int'(lvl));
            chk("count_track", int'(press_count), int'(cnt));
        end
    end

    task automatic drive(bit v, int n);
        button_in = v;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int len;
        bit v;
        repeat (3) @(negedge clk);
        #1;
        chk("init_debounced", int'(debounced), 0);
        chk("init_count", int'(press_count), 0);
        reset = 1'b0;
        drive(0, 5);

        // clean press and release
        drive(1, 20);
        chk("t1_debounced", int'(debounced), 1);
        chk("t1_count", int'(press_count), 1);
        drive(0, 20);
        chk("t1_released", int'(debounced), 0);

        // bounce shorter than qualification
        drive(1, 9);
        drive(0, 20);
        chk("t2_debounced", int'(debounced), 0);
        chk("t2_count", int'(press_count), 1);

        // long hold
        drive(1, 60);
        drive(0, 20);

        // release glitch while pressed
        drive(1, 30);
        drive(0, 5);
        chk("t4_glitch_level", int'(debounced), 1);
        drive(1, 10);
        drive(0, 20);

        // reset mid WAIT_PRESS with button held
        drive(1, 6);
        reset = 1'b1;
        #1;
        chk("t6_reset_debounced", int'(debounced), 0);
        chk("t6_reset_count", int'(press_count), 0);
        chk("t6_reset_press", int'(press_pulse), 0);
        drive(1, 3);
        reset = 1'b0;
        drive(1, 20);
        drive(0, 20);

        // wrap of press_count after 256 presses
        reset = 1'b1;
        drive(0, 3);
        reset = 1'b0;
        drive(0, 4);
        for (int i = 0; i < 256; i++) begin
            drive(1, 16);
            drive(0, 16);
        end
        chk("t6_count_wrap", int'(press_count), 0);

        // random runs
        v = 1'b0;
        for (int i = 0; i < 200; i++) begin
            v = ~v;
            if ($urandom_range(0, 9) < 7) len = $urandom_range(1, 16);
            else len = $urandom_range(17, 60);
            drive(v, len);
        end

        drive(0, 40);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
